// File: rtl/pe_op_sequencer.sv
// Control sequencer for one GF(3^M) processing element operation.
// Accepts one command per valid/ready handshake, then walks the PE through
// clear -> load -> run and pulses done when the PE output is valid.
// Every output is a register; nothing combinational reaches the ports.
module pe_op_sequencer #(
  parameter int unsigned MULT_CYCLES = 198,
  parameter int unsigned CNT_W       = 8,
  parameter logic [10:0] CTRL_LOAD   = 11'b11111_000000,
  parameter logic [10:0] CTRL_MULT   = 11'b00000_111111,
  parameter logic [10:0] CTRL_CUBE   = 11'b00000_000001,
  parameter logic [10:0] CTRL_ADDSUB = 11'b00000_010001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op,
  output logic        pe_reset,
  output logic [10:0] pe_ctrl,
  output logic        d0_ovr,
  output logic [5:0]  d0_mode,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StRun,
    StDone
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] count;

  // d0 mode field forced into the PE operand for each op
  function automatic logic [5:0] mode_of(input logic [1:0] o);
    case (o)
      2'd1:    return 6'b010101;
      2'd2:    return 6'b000101;
      2'd3:    return 6'b001001;
      default: return 6'b000000;
    endcase
  endfunction

  // PE control word held during the run phase
  function automatic logic [10:0] run_word_of(input logic [1:0] o);
    case (o)
      2'd0:    return CTRL_MULT;
      2'd1:    return CTRL_CUBE;
      default: return CTRL_ADDSUB;
    endcase
  endfunction

  // Sequencer FSM; each branch assigns the outputs for the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= StIdle;
      op_q     <= 2'd0;
      count    <= '0;
      op_ready <= 1'b1;
      pe_reset <= 1'b1;
      pe_ctrl  <= 11'd0;
      d0_ovr   <= 1'b0;
      d0_mode  <= 6'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The done cycle already reports ready, so a held command is taken
        // on the edge that ends it and back-to-back ops lose no cycle.
        StIdle, StDone: begin
          if (op_valid) begin
            state    <= StClr;
            op_q     <= op;
            d0_mode  <= mode_of(op);
            d0_ovr   <= (op != 2'd0);
            op_ready <= 1'b0;
            busy     <= 1'b1;
            pe_reset <= 1'b1;
            pe_ctrl  <= 11'd0;
          end else begin
            state    <= StIdle;
            op_ready <= 1'b1;
            busy     <= 1'b0;
            pe_reset <= 1'b0;
            pe_ctrl  <= 11'd0;
            d0_ovr   <= 1'b0;
          end
        end
        StClr: begin
          state    <= StLoad;
          pe_reset <= 1'b0;
          pe_ctrl  <= CTRL_LOAD;
        end
        StLoad: begin
          state   <= StRun;
          pe_ctrl <= run_word_of(op_q);
          // Run lasts count+1 cycles; only mult needs more than one
          count   <= (op_q == 2'd0) ? CNT_W'(MULT_CYCLES - 1) : '0;
        end
        StRun: begin
          if (count == '0) begin
            state    <= StDone;
            done     <= 1'b1;
            pe_ctrl  <= 11'd0;
            op_ready <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state    <= StIdle;
          op_ready <= 1'b1;
          busy     <= 1'b0;
          pe_reset <= 1'b0;
          pe_ctrl  <= 11'd0;
          d0_ovr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Self-checking bench for pe_op_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// timeline model (cycle offset since acceptance -> expected outputs).
module tb_pe_op_sequencer;

  localparam int MULT = 198;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        op_ready;
  logic        pe_reset;
  logic [10:0] pe_ctrl;
  logic        d0_ovr;
  logic [5:0]  d0_mode;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  // Model state: an op is "active" for t = 1 .. n+3 cycles after its accept edge
  bit         m_active = 1'b0;
  bit         m_fresh = 1'b1;
  int         m_t = 0;
  int         m_n = 0;
  logic [1:0] m_op = 2'd0;

  pe_op_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .pe_reset (pe_reset),
    .pe_ctrl  (pe_ctrl),
    .d0_ovr   (d0_ovr),
    .d0_mode  (d0_mode),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int n_of(input logic [1:0] o);
    return (o == 2'd0) ? MULT : 1;
  endfunction

  function automatic logic [10:0] run_of(input logic [1:0] o);
    return (o == 2'd0) ? 11'h03F : (o == 2'd1) ? 11'h001 : 11'h011;
  endfunction

  function automatic logic [5:0] mode_of(input logic [1:0] o);
    case (o)
      2'd1:    return 6'h15;
      2'd2:    return 6'h05;
      2'd3:    return 6'h09;
      default: return 6'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    if (!reset_n) return;
    m_fresh = 1'b0;
    if ((!m_active || m_t == m_n + 3) && op_valid) begin
      m_active = 1'b1;
      m_t = 1;
      m_op = op;
      m_n = n_of(op);
    end else if (m_active) begin
      m_t++;
      if (m_t > m_n + 3) m_active = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [10:0] e_ctrl;
    if (m_active) begin
      if (m_t == 1) e_ctrl = 11'h000;
      else if (m_t == 2) e_ctrl = 11'h7C0;
      else if (m_t <= m_n + 2) e_ctrl = run_of(m_op);
      else e_ctrl = 11'h000;
      check("op_ready", op_ready, (m_t == m_n + 3));
      check("busy", busy, 1);
      check("pe_reset", pe_reset, (m_t == 1));
      check("pe_ctrl", pe_ctrl, e_ctrl);
      check("done", done, (m_t == m_n + 3));
      check("d0_ovr", d0_ovr, (m_op != 2'd0));
      check("d0_mode", d0_mode, mode_of(m_op));
    end else begin
      check("op_ready", op_ready, 1);
      check("busy", busy, 0);
      check("pe_reset", pe_reset, m_fresh);
      check("pe_ctrl", pe_ctrl, 0);
      check("done", done, 0);
      check("d0_ovr", d0_ovr, 0);
      if (m_fresh) check("d0_mode", d0_mode, 0);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1ns later
  task automatic step(input logic v, input logic [1:0] o);
    @(negedge clk);
    op_valid = v;
    op = o;
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react before any edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst pe_ctrl", pe_ctrl, 11'h000);
    check("rst pe_reset", pe_reset, 1);
    check("rst busy", busy, 0);
    check("rst op_ready", op_ready, 1);
    check("rst done", done, 0);
    m_active = 1'b0;
    m_fresh = 1'b1;
    step(1'b0, 2'd0);
    step(1'b1, 2'd0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    int k2;
    int done_e;
    int cnt3f;
    int ovr_cnt;
    int early_ready;
    int done_cnt;
    logic [10:0] seq_ctrl [4];
    logic        seq_done [4];

    #12;
    reset_n = 1'b1;
    step(1'b0, 2'd0);
    check("idle op_ready", op_ready, 1);
    check("idle pe_reset", pe_reset, 0);

    // Mult, with a stray sub command pulsed while running
    step(1'b1, 2'd0);
    k = edge_no;
    cnt3f = 0; ovr_cnt = 0; early_ready = 0; done_e = -1;
    for (int i = 0; i < 400 && done_e < 0; i++) begin
      if (i == 50) step(1'b1, 2'd3);
      else step(1'b0, 2'd0);
      if (pe_ctrl == 11'h03F) cnt3f++;
      if (d0_ovr) ovr_cnt++;
      if (op_ready && !done) early_ready++;
      if (done) done_e = edge_no;
    end
    check("mult latency", done_e - k, 200);
    check("mult run cycles", cnt3f, 198);
    check("mult d0_ovr cycles", ovr_cnt, 0);
    check("mult early ready", early_ready, 0);
    repeat (3) step(1'b0, 2'd0);

    // Cube
    step(1'b1, 2'd1);
    check("cube d0_ovr", d0_ovr, 1);
    check("cube d0_mode", d0_mode, 6'h15);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0);
      seq_ctrl[i] = pe_ctrl;
      seq_done[i] = done;
    end
    check("cube load word", seq_ctrl[0], 11'h7C0);
    check("cube run word", seq_ctrl[1], 11'h001);
    check("cube done at k+3", seq_done[2], 1);
    check("cube done once", seq_done[1] | seq_done[3], 0);

    // Add then sub with op_valid held high
    k = -1; k2 = -1;
    for (int i = 0; i < 20 && k2 < 0; i++) begin
      step(1'b1, (k < 0) ? 2'd2 : 2'd3);
      if (pe_reset) begin
        if (k < 0) begin
          k = edge_no;
          check("add d0_mode", d0_mode, 6'h05);
        end else begin
          k2 = edge_no;
          check("sub d0_mode", d0_mode, 6'h09);
        end
      end else if (pe_ctrl != 11'h7C0 && pe_ctrl != 11'h000) begin
        check("addsub run word", pe_ctrl, 11'h011);
      end
    end
    check("sub accept spacing", k2 - k, 4);
    repeat (6) step(1'b0, 2'd0);

    // Reset in the middle of a mult run: no done afterwards
    step(1'b1, 2'd0);
    repeat (60) step(1'b0, 2'd0);
    do_reset();
    done_cnt = 0;
    for (int i = 0; i < 220; i++) begin
      step(1'b0, 2'd0);
      if (done) done_cnt++;
    end
    check("no done after abort", done_cnt, 0);

    // Randomized traffic; the caller holds a command until it is accepted
    begin
      logic       hold_v;
      logic [1:0] hold_op;
      hold_v = 1'b0;
      hold_op = 2'd0;
      for (int i = 0; i < 6000; i++) begin
        if (!hold_v && $urandom_range(0, 3) == 0) begin
          hold_v = 1'b1;
          hold_op = ($urandom_range(0, 4) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        end
        if ($urandom_range(0, 799) == 0) begin
          do_reset();
          hold_v = 1'b0;
        end else begin
          step(hold_v, hold_op);
          if (hold_v && pe_reset && m_active && m_t == 1) hold_v = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
